// File: rtl/adc_pair_capture.sv
// ADC front-end capture: registers the offset-binary stream, frames it on a SynchrM
// rising edge and writes formatted even/odd sample pairs to the pair buffer RAMs.
//
// state      | meaning
// IDLE       | waiting for a synchronized SynchrM edge with Enable high
// ARMED      | counting down PRE_DELAY samples before sample 0
// CAPTURE    | pairing samples, one RAM write every second cycle
// DONE       | frame complete: FrameDone pulse, then back to IDLE
module adc_pair_capture #(
    parameter int FRAME_PAIRS = 2176,
    parameter int PRE_DELAY   = 0,
    parameter bit SIGNED_OUT  = 1'b1
) (
    input  logic        ClockFromADC,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        SynchrM,
    input  logic [13:0] AdcData,
    input  logic        AdcOvr,
    output logic [13:0] EvenData,
    output logic [13:0] OddData,
    output logic [11:0] PairAddr,
    output logic        PairWe,
    output logic        Busy,
    output logic        FrameDone,
    output logic        OvrSticky,
    output logic        SyncMissed,
    output logic [15:0] FrameCount
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [7:0]  DELAY_INIT = 8'(PRE_DELAY);
    localparam logic [11:0] LAST_PAIR  = 12'(FRAME_PAIRS - 1);

    logic [1:0]  state;
    logic        sync1, sync2, sync3;
    logic        sync_edge;
    logic [13:0] s1_data;
    logic        s1_ovr;
    logic        s1_bad;
    logic [7:0]  delay_cnt;
    logic [11:0] pair_cnt;
    logic        odd_phase;
    logic [13:0] even_hold;
    logic        done_step;

    function automatic logic [13:0] fmt(input logic [13:0] d);
        if (SIGNED_OUT)
            return {~d[13], d[12:0]};
        return d;
    endfunction

    assign sync_edge = sync2 & ~sync3;
    // Full-scale codes are treated as clipping even when the ADC pin stays low.
    assign s1_bad    = s1_ovr | (s1_data == 14'h0000) | (s1_data == 14'h3FFF);
    assign Busy      = (state == ST_ARMED) || (state == ST_CAPTURE);

    always_ff @(posedge ClockFromADC) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            s1_data    <= 14'h0000;
            s1_ovr     <= 1'b0;
            delay_cnt  <= 8'd0;
            pair_cnt   <= 12'd0;
            odd_phase  <= 1'b0;
            even_hold  <= 14'h0000;
            done_step  <= 1'b0;
            EvenData   <= 14'h0000;
            OddData    <= 14'h0000;
            PairAddr   <= 12'd0;
            PairWe     <= 1'b0;
            FrameDone  <= 1'b0;
            OvrSticky  <= 1'b0;
            SyncMissed <= 1'b0;
            FrameCount <= 16'd0;
        end else begin
            sync1     <= SynchrM;
            sync2     <= sync1;
            sync3     <= sync2;
            s1_data   <= AdcData;
            s1_ovr    <= AdcOvr;
            PairWe    <= 1'b0;
            FrameDone <= 1'b0;

            if (sync_edge && (state != ST_IDLE))
                SyncMissed <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (sync_edge && Enable) begin
                        state     <= ST_ARMED;
                        delay_cnt <= DELAY_INIT;
                        OvrSticky <= 1'b0;
                        pair_cnt  <= 12'd0;
                        odd_phase <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (!Enable)
                        state <= ST_IDLE;
                    else if (delay_cnt == 8'd0)
                        state <= ST_CAPTURE;
                    else
                        delay_cnt <= delay_cnt - 8'd1;
                end
                ST_CAPTURE: begin
                    if (!Enable) begin
                        state <= ST_IDLE;
                    end else begin
                        if (s1_bad)
                            OvrSticky <= 1'b1;
                        if (!odd_phase) begin
                            even_hold <= s1_data;
                            odd_phase <= 1'b1;
                        end else begin
                            PairWe    <= 1'b1;
                            PairAddr  <= pair_cnt;
                            EvenData  <= fmt(even_hold);
                            OddData   <= fmt(s1_data);
                            odd_phase <= 1'b0;
                            if (pair_cnt == LAST_PAIR) begin
                                state     <= ST_DONE;
                                done_step <= 1'b0;
                            end else begin
                                pair_cnt <= pair_cnt + 12'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    // First cycle raises FrameDone, second returns to IDLE.
                    if (!done_step) begin
                        FrameDone  <= 1'b1;
                        FrameCount <= FrameCount + 16'd1;
                        done_step  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_pair_capture.sv
// Self-checking bench for adc_pair_capture: a full-size instance checked every cycle
// against a time-indexed frame model, plus a short PRE_DELAY=5 instance driven from a vector table.
module tb_adc_pair_capture;

    localparam int MAIN_PAIRS = 2176;
    localparam int MAIN_DELAY = 0;
    localparam int DLY_PAIRS  = 6;
    localparam int DLY_DELAY  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        synchr = 1'b0;
    logic [13:0] adc_data = 14'h0000;
    logic        adc_ovr = 1'b0;

    logic [13:0] m_even, m_odd, d_even, d_odd;
    logic [11:0] m_addr, d_addr;
    logic        m_we, m_busy, m_done, m_ovr, m_missed;
    logic        d_we, d_busy, d_done, d_ovr, d_missed;
    logic [15:0] m_count, d_count;

    always #5 clk = ~clk;

    adc_pair_capture #(.FRAME_PAIRS(MAIN_PAIRS), .PRE_DELAY(MAIN_DELAY), .SIGNED_OUT(1'b1)) u_main (
        .ClockFromADC(clk), .Reset(reset), .Enable(enable), .SynchrM(synchr),
        .AdcData(adc_data), .AdcOvr(adc_ovr),
        .EvenData(m_even), .OddData(m_odd), .PairAddr(m_addr), .PairWe(m_we),
        .Busy(m_busy), .FrameDone(m_done), .OvrSticky(m_ovr), .SyncMissed(m_missed),
        .FrameCount(m_count)
    );

    adc_pair_capture #(.FRAME_PAIRS(DLY_PAIRS), .PRE_DELAY(DLY_DELAY), .SIGNED_OUT(1'b1)) u_dly (
        .ClockFromADC(clk), .Reset(reset), .Enable(enable), .SynchrM(synchr),
        .AdcData(adc_data), .AdcOvr(adc_ovr),
        .EvenData(d_even), .OddData(d_odd), .PairAddr(d_addr), .PairWe(d_we),
        .Busy(d_busy), .FrameDone(d_done), .OvrSticky(d_ovr), .SyncMissed(d_missed),
        .FrameCount(d_count)
    );

    typedef struct {
        logic [13:0] even_in;
        logic [13:0] odd_in;
        logic [13:0] even_exp;
        logic [13:0] odd_exp;
        logic        ovr_exp;
    } vec_t;
    vec_t vecs [DLY_PAIRS];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int data_mode = 0;
    int ramp_base = 0;
    int tbl_t     = -100;
    int inject_at = -1;
    int ovr_at    = -1;

    int          obs_writes = 0;
    int          obs_done   = 0;
    int          first_we_edge = -1;
    logic [11:0] first_addr;
    logic [13:0] first_even, first_odd, last_even;

    // Input history indexed by the edge number that sampled it.
    logic [13:0] hist_d   [0:65535];
    bit          hist_o   [0:65535];
    bit          hist_s   [0:65535];
    bit          hist_en  [0:65535];
    bit          hist_rst [0:65535];

    int          mode = 0;
    int          t0m  = 0;
    int          kw   = 0;
    logic        e_we = 1'b0, e_done = 1'b0, e_ovr = 1'b0, e_missed = 1'b0, e_busy = 1'b0;
    logic [11:0] e_addr = 12'd0;
    logic [13:0] e_even = 14'h0000, e_odd = 14'h0000;
    logic [15:0] e_count = 16'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: actual %h required %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] main_out();
        return {3'b000, m_we, m_addr, m_even, m_odd, m_busy, m_done, m_ovr, m_missed, m_count};
    endfunction

    function automatic logic [63:0] model_out();
        return {3'b000, e_we, e_addr, e_even, e_odd, e_busy, e_done, e_ovr, e_missed, e_count};
    endfunction

    // Frame model: from the sync edge t0, sample i is the value sampled at edge
    // t0+D+1+i, pair n is written at edge t0+D+3+2n, done follows the last write.
    task automatic model_step(input int k);
        bit ev;
        int m, n;
        e_we   = 1'b0;
        e_done = 1'b0;
        if (!hist_rst[k]) begin
            mode = 0; e_addr = 0; e_even = 0; e_odd = 0;
            e_ovr = 0; e_missed = 0; e_count = 0;
        end else begin
            ev = (k >= 3) && hist_s[k-2] && !hist_s[k-3] && hist_rst[k-1] && hist_rst[k-2];
            if (mode == 1) begin
                if (ev) e_missed = 1'b1;
                if (!hist_en[k]) begin
                    mode = 0;
                end else begin
                    m = k - (t0m + MAIN_DELAY + 2);
                    if (m >= 0 && m < 2*MAIN_PAIRS &&
                        (hist_o[k-1] || hist_d[k-1] == 14'h0000 || hist_d[k-1] == 14'h3FFF))
                        e_ovr = 1'b1;
                    if (m >= 1 && (m % 2) == 1) begin
                        n      = (m - 1) / 2;
                        e_we   = 1'b1;
                        e_addr = 12'(n);
                        e_even = hist_d[k-2] ^ 14'h2000;
                        e_odd  = hist_d[k-1] ^ 14'h2000;
                        if (n == MAIN_PAIRS - 1) begin
                            mode = 2;
                            kw   = k;
                        end
                    end
                end
            end else if (mode == 2) begin
                if (ev) e_missed = 1'b1;
                if (k == kw + 1) begin
                    e_done  = 1'b1;
                    e_count = e_count + 16'd1;
                end
                if (k == kw + 2) mode = 0;
            end else if (ev && hist_en[k]) begin
                mode  = 1;
                t0m   = k;
                e_ovr = 1'b0;
            end
        end
        e_busy = (mode == 1);
    endtask

    task automatic tick();
        int k, idx;
        k   = cyc + 1;
        idx = k - tbl_t;
        if (idx >= 0 && idx < 2*DLY_PAIRS)
            adc_data = idx[0] ? vecs[idx/2].odd_in : vecs[idx/2].even_in;
        else if (data_mode == 1)
            adc_data = 14'(ramp_base + k);
        else
            adc_data = 14'($urandom_range(16382, 1));
        if (k == inject_at) adc_data = 14'h3FFF;
        adc_ovr = (k == ovr_at);
        hist_d[k] = adc_data; hist_o[k] = adc_ovr; hist_s[k] = synchr;
        hist_en[k] = enable;  hist_rst[k] = reset;
        @(posedge clk);
        #1;
        cyc = k;
        model_step(k);
        check("cycle_outputs", main_out(), model_out());
        if (m_we) begin
            if (obs_writes == 0) begin
                first_we_edge = k;
                first_addr    = m_addr;
                first_even    = m_even;
                first_odd     = m_odd;
            end
            last_even = m_even;
            obs_writes++;
        end
        if (m_done) obs_done++;
    endtask

    task automatic clear_obs();
        obs_writes = 0;
        obs_done = 0;
        first_we_edge = -1;
    endtask

    task automatic pulse_sync(output int t0_exp);
        synchr = 1'b1;
        tick();
        t0_exp = cyc + 2;
        tick();
        tick();
        synchr = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int b = 0;
        while (obs_writes < target && b < 6000) begin
            tick();
            b++;
        end
        check("writes_reached", 64'(obs_writes), 64'(target));
    endtask

    task automatic wait_done();
        int b = 0;
        while (obs_done == 0 && b < 6000) begin
            tick();
            b++;
        end
        check("frame_done_seen", 64'(obs_done), 64'd1);
        tick();
        tick();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0, tmp, s0;

        vecs[0] = '{14'h2000, 14'h2001, 14'h0000, 14'h0001, 1'b0};
        vecs[1] = '{14'h1FFF, 14'h2ABC, 14'h3FFF, 14'h0ABC, 1'b0};
        vecs[2] = '{14'h3F00, 14'h0100, 14'h1F00, 14'h2100, 1'b0};
        vecs[3] = '{14'h0000, 14'h1234, 14'h2000, 14'h3234, 1'b1};
        vecs[4] = '{14'h3FFF, 14'h2000, 14'h1FFF, 14'h0000, 1'b1};
        vecs[5] = '{14'h0001, 14'h3FFE, 14'h2001, 14'h1FFE, 1'b1};

        reset = 1'b0;
        tick();
        check("reset_state", main_out(), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        repeat (4) tick();

        // Frame 1: vector table through the PRE_DELAY=5 instance, then a missed sync.
        clear_obs();
        pulse_sync(t0);
        tbl_t = t0 + DLY_DELAY + 1;
        for (int r = 0; r < DLY_PAIRS; r++) begin
            while (cyc < t0 + DLY_DELAY + 3 + 2*r) tick();
            check("dly_we",   64'(d_we),   64'd1);
            check("dly_addr", 64'(d_addr), 64'(r));
            check("dly_even", 64'(d_even), 64'(vecs[r].even_exp));
            check("dly_odd",  64'(d_odd),  64'(vecs[r].odd_exp));
            check("dly_ovr",  64'(d_ovr),  64'(vecs[r].ovr_exp));
        end
        tick();
        check("dly_done",  64'(d_done),  64'd1);
        check("dly_count", 64'(d_count), 64'd1);
        tick();
        check("dly_idle",   64'({d_busy, d_done}), 64'd0);
        check("dly_missed", 64'(d_missed), 64'd0);
        tbl_t = -100;
        wait_writes(600);
        pulse_sync(tmp);
        wait_done();
        check("f1_writes",   64'(obs_writes), 64'(MAIN_PAIRS));
        check("f1_done",     64'(obs_done),   64'd1);
        check("f1_first_we", 64'(first_we_edge), 64'(t0 + 3));
        check("f1_first_addr", 64'(first_addr), 64'd0);
        check("f1_count",    64'(m_count),   64'd1);
        check("f1_missed",   64'(m_missed),  64'd1);
        repeat (4) tick();

        // Frame 2: ramp with a full-scale code injected at pair 100.
        data_mode = 1;
        ramp_base = 100 - cyc;
        clear_obs();
        pulse_sync(t0);
        check("f2_ovr_cleared_armed", 64'(m_ovr), 64'd0);
        s0 = ramp_base + t0 + 1;
        inject_at = t0 + 1 + 200;
        wait_writes(100);
        check("f2_ovr_before_inject", 64'(m_ovr), 64'd0);
        wait_done();
        inject_at = -1;
        data_mode = 0;
        check("f2_writes",     64'(obs_writes), 64'(MAIN_PAIRS));
        check("f2_first_even", 64'(first_even), 64'(14'(s0) ^ 14'h2000));
        check("f2_first_odd",  64'(first_odd),  64'(14'(s0 + 1) ^ 14'h2000));
        check("f2_last_even",  64'(last_even),  64'(14'(s0 + 2*(MAIN_PAIRS-1)) ^ 14'h2000));
        check("f2_ovr_end",    64'(m_ovr),      64'd1);
        check("f2_count",      64'(m_count),    64'd2);
        repeat (4) tick();

        // Frame 3: Enable dropped at pair 500.
        clear_obs();
        pulse_sync(t0);
        wait_writes(500);
        enable = 1'b0;
        tick();
        check("f3_busy_low", 64'(m_busy), 64'd0);
        repeat (20) tick();
        check("f3_writes", 64'(obs_writes), 64'd500);
        check("f3_done",   64'(obs_done),   64'd0);
        check("f3_count",  64'(m_count),    64'd2);
        enable = 1'b1;
        repeat (5) tick();

        // Frame 4: reset at pair 1000.
        clear_obs();
        pulse_sync(t0);
        wait_writes(1000);
        reset = 1'b0;
        tick();
        check("f4_reset_outputs", main_out(), 64'd0);
        reset = 1'b1;
        repeat (6) tick();
        check("f4_no_more_writes", 64'(obs_writes), 64'd1000);
        check("f4_done", 64'(obs_done), 64'd0);

        // Frame 5: full frame after reset with a pin overrange at pair 300.
        clear_obs();
        pulse_sync(t0);
        ovr_at = t0 + 1 + 600;
        wait_writes(300);
        check("f5_ovr_before", 64'(m_ovr), 64'd0);
        wait_done();
        ovr_at = -1;
        check("f5_writes",     64'(obs_writes), 64'(MAIN_PAIRS));
        check("f5_first_addr", 64'(first_addr), 64'd0);
        check("f5_first_we",   64'(first_we_edge), 64'(t0 + 3));
        check("f5_ovr_end",    64'(m_ovr),      64'd1);
        check("f5_count",      64'(m_count),    64'd1);
        check("f5_missed",     64'(m_missed),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
